// File: rtl/ddp_hs_pkg.sv
// Shared definitions for the data-driven pipeline handshake blocks (branch, arbiter/merge).
// Holds the state encodings and the four-phase handshake constants.
package ddp_hs_pkg;

    localparam int DW_DEFAULT = 32;

    // Four-phase Send/Ack: req up, ack up, req down, ack down.
    localparam int   HS_PHASES    = 4;
    localparam logic HS_ASSERTED  = 1'b1;
    localparam logic HS_RELEASED  = 1'b0;

    typedef enum logic {
        I_IDLE = 1'b0,
        I_ACK  = 1'b1
    } in_state_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD  = 2'd1,
        S_SEND  = 2'd2,
        S_RTZ   = 2'd3
    } slot_state_t;

endpackage

// File: rtl/token_branch_if.sv
// Channel bundle of the token branch: one upstream Send/Ack channel, two downstream
// channels with enables and delivery counters.
interface token_branch_if import ddp_hs_pkg::*; #(
    parameter int DW    = DW_DEFAULT,
    parameter int CNT_W = 16
);
    logic             BR_Send_in;
    logic [DW-1:0]    BR_Data_in;
    logic             BR_Ack_in;
    logic             BR_Za;
    logic             BR_Zb;
    logic             BR_Send_out_a;
    logic             BR_Send_out_b;
    logic             BR_Ack_out_a;
    logic             BR_Ack_out_b;
    logic [DW-1:0]    BR_Data_out_a;
    logic [DW-1:0]    BR_Data_out_b;
    logic [CNT_W-1:0] BR_Cnt_a;
    logic [CNT_W-1:0] BR_Cnt_b;

    modport master (
        output BR_Send_in, BR_Data_in, BR_Za, BR_Zb, BR_Ack_out_a, BR_Ack_out_b,
        input  BR_Ack_in, BR_Send_out_a, BR_Send_out_b,
        input  BR_Data_out_a, BR_Data_out_b, BR_Cnt_a, BR_Cnt_b
    );

    modport slave (
        input  BR_Send_in, BR_Data_in, BR_Za, BR_Zb, BR_Ack_out_a, BR_Ack_out_b,
        output BR_Ack_in, BR_Send_out_a, BR_Send_out_b,
        output BR_Data_out_a, BR_Data_out_b, BR_Cnt_a, BR_Cnt_b
    );
endinterface

// File: rtl/token_branch_slot.sv
// One output slot of the branch: holds a token until its downstream four-phase
// handshake completes, and counts completed deliveries (saturating).
module token_branch_slot import ddp_hs_pkg::*; #(
    parameter int DW    = DW_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             mr,
    input  logic             load,
    input  logic             z,
    input  logic             ack_out,
    input  logic [DW-1:0]    data_in,
    output logic             send_out,
    output logic             empty,
    output logic [DW-1:0]    data_out,
    output logic [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    slot_state_t      state_r;
    slot_state_t      state_next_s;
    logic [DW-1:0]    data_r;
    logic [CNT_W-1:0] cnt_r;
    logic             deliver_s;

    // Slot state register.
    always_ff @(posedge clk) begin
        if (mr) state_r <= S_EMPTY;
        else    state_r <= state_next_s;
    end

    // Slot next-state: enable only matters before SEND; ack only matters from SEND on.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_EMPTY: if (load)     state_next_s = z ? S_SEND : S_HOLD;
                     else          state_next_s = S_EMPTY;
            S_HOLD:  if (z)        state_next_s = S_SEND;
                     else          state_next_s = S_HOLD;
            S_SEND:  if (ack_out)  state_next_s = S_RTZ;
                     else          state_next_s = S_SEND;
            S_RTZ:   if (!ack_out) state_next_s = S_EMPTY;
                     else          state_next_s = S_RTZ;
            default:               state_next_s = S_EMPTY;
        endcase
    end

    // Slot output decode.
    always_comb begin
        send_out  = (state_r == S_SEND);
        empty     = (state_r == S_EMPTY);
        deliver_s = (state_r == S_RTZ) && !ack_out;
    end

    // Token register; keeps the last loaded token after delivery.
    always_ff @(posedge clk) begin
        if (mr)                             data_r <= '0;
        else if (load && state_r == S_EMPTY) data_r <= data_in;
        else                                data_r <= data_r;
    end

    // Delivered-token counter, bumps on RTZ -> EMPTY and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (mr)                                cnt_r <= '0;
        else if (deliver_s && cnt_r != CNT_MAX) cnt_r <= cnt_r + CNT_ONE;
        else                                   cnt_r <= cnt_r;
    end

    assign data_out = data_r;
    assign cnt      = cnt_r;

endmodule

// File: rtl/token_branch.sv
// Two-way token branch: accepts one upstream token at a time and steers it by its
// destination bit into output slot A (bit=0) or B (bit=1).
module token_branch import ddp_hs_pkg::*; #(
    parameter int DW      = DW_DEFAULT,
    parameter int SEL_BIT = DW - 1,
    parameter int CNT_W   = 16
) (
    input logic           CLK,
    input logic           MR,
    token_branch_if.slave br
);
    in_state_t in_state_r;
    in_state_t in_state_next_s;
    logic      sel_s;
    logic      dest_empty_s;
    logic      accept_s;
    logic      load_a_s;
    logic      load_b_s;
    logic      empty_a_s;
    logic      empty_b_s;

    // Steering: a token is only taken when its own slot is free; the other slot never blocks it.
    always_comb begin
        sel_s        = br.BR_Data_in[SEL_BIT];
        dest_empty_s = sel_s ? empty_b_s : empty_a_s;
        accept_s     = (in_state_r == I_IDLE) && br.BR_Send_in && dest_empty_s;
        load_a_s     = accept_s && !sel_s;
        load_b_s     = accept_s && sel_s;
    end

    // Input state register.
    always_ff @(posedge CLK) begin
        if (MR) in_state_r <= I_IDLE;
        else    in_state_r <= in_state_next_s;
    end

    // Input next-state.
    always_comb begin
        in_state_next_s = in_state_r;
        case (in_state_r)
            I_IDLE:  if (accept_s)       in_state_next_s = I_ACK;
                     else                in_state_next_s = I_IDLE;
            I_ACK:   if (!br.BR_Send_in) in_state_next_s = I_IDLE;
                     else                in_state_next_s = I_ACK;
            default:                     in_state_next_s = I_IDLE;
        endcase
    end

    // Input output decode.
    always_comb begin
        br.BR_Ack_in = (in_state_r == I_ACK);
    end

    token_branch_slot #(.DW(DW), .CNT_W(CNT_W)) u_slot_a (
        .clk      (CLK),
        .mr       (MR),
        .load     (load_a_s),
        .z        (br.BR_Za),
        .ack_out  (br.BR_Ack_out_a),
        .data_in  (br.BR_Data_in),
        .send_out (br.BR_Send_out_a),
        .empty    (empty_a_s),
        .data_out (br.BR_Data_out_a),
        .cnt      (br.BR_Cnt_a)
    );

    token_branch_slot #(.DW(DW), .CNT_W(CNT_W)) u_slot_b (
        .clk      (CLK),
        .mr       (MR),
        .load     (load_b_s),
        .z        (br.BR_Zb),
        .ack_out  (br.BR_Ack_out_b),
        .data_in  (br.BR_Data_in),
        .send_out (br.BR_Send_out_b),
        .empty    (empty_b_s),
        .data_out (br.BR_Data_out_b),
        .cnt      (br.BR_Cnt_b)
    );

endmodule
